// File: rtl/vote_arbiter.sv
// vote_arbiter: round-robin arbiter sharing one bit-serial majority-vote engine.
// Each granted ballot is counted one bit per cycle; the verdict (ones > THRESH)
// is returned over a valid/ready handshake tagged with the requester id.
// Optional: define VOTE_ARBITER_EARLY_EXIT_EN to stop counting once no ones remain.
module vote_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned WIDTH  = 7,
  parameter int unsigned THRESH = 3,
  localparam int unsigned IDW   = $clog2(NREQ),
  localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out,
  output logic [IDW-1:0]        out_id
);

  localparam int unsigned SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IDW-1:0]    last_q, last_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [CW-1:0]     sum_q, sum_d;
  logic [SW-1:0]     step_q, step_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic              out_q, out_d;
  logic [IDW-1:0]    out_id_q, out_id_d;

  logic [IDW-1:0]    win_c;
  logic [CW-1:0]     sum_nx_c;
  logic              last_step_c;

  // Round-robin winner: first set req bit searching upward from last+1 with wrap
  always_comb begin
    win_c = '0;
    for (int unsigned off = NREQ; off >= 1; off--) begin
      int unsigned idx;
      idx = (32'(last_q) + off) % NREQ;
      if (req[idx]) win_c = IDW'(idx);
    end
  end

  // Running sum including the bit consumed this cycle, and end-of-count detect
  always_comb begin
    sum_nx_c    = sum_q + CW'(sh_q[0]);
    last_step_c = (step_q == SW'(WIDTH - 1));
`ifdef VOTE_ARBITER_EARLY_EXIT_EN
    if ((sh_q >> 1) == '0) last_step_c = 1'b1;
`else
`endif
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    sh_d        = sh_q;
    sum_d       = sum_q;
    step_d      = step_q;
    id_d        = id_q;
    gnt_d       = '0;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_id_d    = out_id_q;

    case (state_q)
      IDLE: begin
        if (|req) begin
          sh_d    = data_in[32'(win_c)*WIDTH +: WIDTH];
          sum_d   = '0;
          step_d  = '0;
          id_d    = win_c;
          last_d  = win_c;
          gnt_d   = NREQ'(1) << win_c;
          state_d = COUNT;
        end
      end
      COUNT: begin
        sum_d  = sum_nx_c;
        sh_d   = sh_q >> 1;
        step_d = step_q + SW'(1);
        if (last_step_c) begin
          out_d       = (32'(sum_nx_c) > 32'(THRESH));
          out_id_d    = id_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= IDW'(NREQ - 1);
      sh_q        <= '0;
      sum_q       <= '0;
      step_q      <= '0;
      id_q        <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= 1'b0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      sh_q        <= sh_d;
      sum_q       <= sum_d;
      step_q      <= step_d;
      id_q        <= id_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_id_q    <= out_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_vote_arbiter.sv
// Directed testbench for vote_arbiter (default parameters NREQ=4, WIDTH=7, THRESH=3).
// Latency expectations follow VOTE_ARBITER_EARLY_EXIT_EN when it is defined.
module tb_vote_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 7;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data_in;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out;
  logic [1:0]            out_id;

  int n_checks = 0;
  int n_pass   = 0;

  vote_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .gnt       (gnt),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Cycles from the negedge after the capture edge until out_valid is seen (bounded)
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  // One complete transaction from a single requester
  task automatic run_one(input int id, input logic [WIDTH-1:0] ballot,
                         input logic exp_out, input int exp_lat, input string tag);
    int lat;
    data_in[id*WIDTH +: WIDTH] = ballot;
    req = NREQ'(1) << id;
    @(negedge clk);
    chk({tag, "_gnt"}, 32'(gnt), 32'(NREQ'(1) << id));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    req = '0;
    @(negedge clk);
    chk({tag, "_gnt_drop"}, 32'(gnt), 32'd0);
    wait_valid(lat);
    chk({tag, "_lat"}, 32'(lat + 1), 32'(exp_lat));
    chk({tag, "_out"}, 32'(out), 32'(exp_out));
    chk({tag, "_id"}, 32'(out_id), 32'(id));
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_vld_clr"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy_clr"}, 32'(busy), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat_a, lat_z, lat_f;
    int prev, cyc, k, lat, seen;
`ifdef VOTE_ARBITER_EARLY_EXIT_EN
    lat_a = 3; lat_z = 1; lat_f = 7;
`else
    lat_a = 7; lat_z = 7; lat_f = 7;
`endif
    rst = 1'b1; req = '0; data_in = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_id", 32'(out_id), 32'd0);

    // Basic verdicts
    run_one(0, 7'b1010001, 1'b0, 7, "b0_3ones");
    run_one(1, 7'b1010101, 1'b1, 7, "b1_4ones");
    run_one(1, 7'b1011001, 1'b1, 7, "b1_4ones_b");
    run_one(2, 7'b0000101, 1'b0, lat_a, "b2_low");
    run_one(3, 7'b0000000, 1'b0, lat_z, "b3_zero");
    run_one(3, 7'b1111111, 1'b1, lat_f, "b3_full");

    // All requesting continuously: pointer at 3, so order 0,1,2,3,0 with WIDTH+2 spacing
    data_in = {NREQ{7'b1000000}};
    out_ready = 1'b1;
    req = 4'b1111;
    cyc = 0; k = 0; prev = 0;
    while (k < 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (gnt != '0) begin
        chk("rr_gnt", 32'(gnt), 32'(NREQ'(1) << (k % NREQ)));
        if (k > 0) chk("rr_spacing", 32'(cyc - prev), 32'(WIDTH + 2));
        prev = cyc;
        k++;
      end
    end
    req = '0;
    chk("rr_count", 32'(k), 32'd5);
    @(negedge clk);
    chk("rr_gnt_width", 32'(gnt), 32'd0);
    wait_idle();
    out_ready = 1'b0;

    // Backpressure: verdict held stable while out_ready is low
    data_in[1*WIDTH +: WIDTH] = 7'b1010101;
    req = 4'b0010;
    @(negedge clk);
    chk("bp_gnt", 32'(gnt), 32'b0010);
    req = '0;
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_out", 32'(out), 32'd1);
      chk("bp_id", 32'(out_id), 32'd1);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_gnt0", 32'(gnt), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_busy", 32'(busy), 32'd0);
    out_ready = 1'b0;

    // Reset in the middle of counting aborts the ballot and resets the pointer
    data_in[2*WIDTH +: WIDTH] = 7'b1111111;
    req = 4'b0100;
    @(negedge clk);
    chk("mr_gnt", 32'(gnt), 32'b0100);
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_out", 32'(out), 32'd0);
    chk("mr_id", 32'(out_id), 32'd0);
    chk("mr_gnt0", 32'(gnt), 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mr_no_valid", 32'(seen), 32'd0);
    data_in[0 +: WIDTH] = 7'b1111000;
    req = 4'b1001;
    @(negedge clk);
    chk("mr_ptr_reset", 32'(gnt), 32'b0001);
    req = '0;
    wait_valid(lat);
    chk("mr_after_out", 32'(out), 32'd1);
    chk("mr_after_id", 32'(out_id), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
